// File: rtl/mul_pkg.sv
// Shared types and default sizing for the sequential shift-add multiplier.
package mul_pkg;

  localparam int MUL_WIDTH = 32;
  localparam int MUL_CNT_W = 6;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE,
    S_FIX
  } state_e;

endpackage

// File: rtl/mul_step_unit.sv
// One shift-add step: conditional add of the multiplicand into the upper half,
// then a 1-bit logical right shift that keeps the add's carry in the top bit.
module mul_step_unit
  import mul_pkg::*;
#(
  parameter int W = MUL_WIDTH
) (
  input  logic           mark,
  input  logic [W-1:0]   mcand,
  input  logic [2*W-1:0] acc,
  output logic [2*W-1:0] next_acc
);

  logic [W:0] upper;

  always_comb begin
    upper    = {1'b0, acc[2*W-1:W]} + (mark ? {1'b0, mcand} : {(W+1){1'b0}});
    next_acc = {upper, acc[W-1:1]};
  end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequential multiplier controller: one add/shift step per clock, start/busy/done handshake.
// Define MUL_SIGNED_EN for a two's-complement multiply with an extra sign-fix cycle.
module mul_seq_ctrl
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int CNT_W = MUL_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] stepAcc;
  logic [WIDTH-1:0]   opA, opB;

`ifdef MUL_SIGNED_EN
  logic neg_q, neg_d;

  // Magnitudes fit in WIDTH bits unsigned, including the most negative value.
  assign opA = multiplicand[WIDTH-1] ? -multiplicand : multiplicand;
  assign opB = multiplier[WIDTH-1]   ? -multiplier   : multiplier;
`else
  assign opA = multiplicand;
  assign opB = multiplier;
`endif

  mul_step_unit #(.W(WIDTH)) u_step (
    .mark     (acc_q[0]),
    .mcand    (mcand_q),
    .acc      (acc_q),
    .next_acc (stepAcc)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    product_d = product_q;
    mcand_d   = mcand_q;
    cnt_d     = cnt_q;
`ifdef MUL_SIGNED_EN
    neg_d     = neg_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (state_q == S_DONE) state_d = S_IDLE;
        if (start) begin
          mcand_d = opA;
          acc_d   = {{WIDTH{1'b0}}, opB};
          cnt_d   = '0;
          state_d = S_RUN;
`ifdef MUL_SIGNED_EN
          neg_d   = multiplicand[WIDTH-1] ^ multiplier[WIDTH-1];
`endif
        end
      end
      S_RUN: begin
        acc_d = stepAcc;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
`ifdef MUL_SIGNED_EN
          state_d = S_FIX;
`else
          state_d   = S_DONE;
          product_d = stepAcc;
`endif
        end
      end
`ifdef MUL_SIGNED_EN
      S_FIX: begin
        product_d = neg_q ? -acc_q : acc_q;
        state_d   = S_DONE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      product_q <= '0;
      mcand_q   <= '0;
      cnt_q     <= '0;
`ifdef MUL_SIGNED_EN
      neg_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      mcand_q   <= mcand_d;
      cnt_q     <= cnt_d;
`ifdef MUL_SIGNED_EN
      neg_q     <= neg_d;
`endif
    end
  end

  assign busy    = (state_q == S_RUN) || (state_q == S_FIX);
  assign done    = (state_q == S_DONE);
  assign product = product_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Scoreboard bench for mul_seq_ctrl; directed and random operands against an arithmetic model.
// Honours MUL_SIGNED_EN the same way as the design.
module tb_mul_seq_ctrl;

  localparam int W = 32;
`ifdef MUL_SIGNED_EN
  localparam int LAT = W + 1;
`else
  localparam int LAT = W;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [W-1:0]     multiplicand = '0;
  logic [W-1:0]     multiplier = '0;
  logic             busy;
  logic             done;
  logic [2*W-1:0]   product;

  typedef struct {
    logic [2*W-1:0] prod;
    int             issue;
  } exp_t;

  exp_t           sbQ[$];
  exp_t           monEntry;
  int             compared = 0;
  int             mismatched = 0;
  int             cycleCount = 0;
  logic [2*W-1:0] lastExpected = '0;

  mul_seq_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  function automatic logic [2*W-1:0] refProduct(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MUL_SIGNED_EN
    logic signed [2*W-1:0] sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    return sa * sb;
`else
    logic [2*W-1:0] ua, ub;
    ua = a;
    ub = b;
    return ua * ub;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycleCount);
    end
  endtask

  // Called at a falling edge; the start is sampled on the next rising edge.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input bit accept, output int issue);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    issue        = cycleCount + 1;
    if (accept) sbQ.push_back('{refProduct(a, b), issue});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while (sbQ.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("doneTimeout", sbQ.size(), 0);
    sbQ.delete();
  endtask

  function automatic logic [W-1:0] pickOperand();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(W-1){1'b0}}};
      default: return $urandom;
    endcase
  endfunction

  // Every done must match the oldest outstanding operation, with the modelled latency.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpectedDone", done, 0);
      end else begin
        monEntry = sbQ.pop_front();
        checkOutput("product", product, monEntry.prod);
        checkOutput("latency", cycleCount - monEntry.issue, LAT);
        checkOutput("busyAtDone", busy, 0);
        lastExpected = monEntry.prod;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int t, t2;
    logic [2*W-1:0] holdExp;

    #1;
    checkOutput("resetBusy", busy, 0);
    checkOutput("resetDone", done, 0);
    checkOutput("resetProduct", product, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Abort mid-operation: outputs clear at once and no done ever appears.
    @(negedge clk);
    applyStimulus(3, 5, 1'b1, t);
    repeat (8) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    sbQ.delete();
    #1;
    checkOutput("abortBusy", busy, 0);
    checkOutput("abortDone", done, 0);
    checkOutput("abortProduct", product, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("abortProductLater", product, 0);

    @(negedge clk);
    applyStimulus('1, '1, 1'b1, t);
    waitIdle(LAT + 10);
`ifdef MUL_SIGNED_EN
    checkOutput("carryProd", product, 64'h1);
`else
    checkOutput("carryProd", product, 64'hFFFF_FFFE_0000_0001);
`endif

    // Second start while busy must be ignored.
    @(negedge clk);
    applyStimulus(6, 7, 1'b1, t);
    repeat (4) @(negedge clk);
    applyStimulus(1, 1, 1'b0, t2);
    waitIdle(LAT + 10);
    checkOutput("basicProd", product, 42);

    // Restart in the DONE cycle with no idle bubble.
    @(negedge clk);
    applyStimulus(32'h1_0000, 32'h1_0000, 1'b1, t);
    while (cycleCount < t + LAT) @(negedge clk);
    checkOutput("b2bFirstProd", product, 64'h1_0000_0000);
    applyStimulus(0, 32'hDEAD_BEEF, 1'b1, t2);
    #1;
    checkOutput("b2bBusy", busy, 1);
    waitIdle(LAT + 10);
    checkOutput("zeroProd", product, 0);

`ifdef MUL_SIGNED_EN
    @(negedge clk);
    applyStimulus(-32'sd7, 32'sd6, 1'b1, t);
    waitIdle(LAT + 10);
    checkOutput("signedNegProd", product, 64'hFFFF_FFFF_FFFF_FFD6);
    @(negedge clk);
    applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b1, t);
    waitIdle(LAT + 10);
    checkOutput("signedMinProd", product, 64'h4000_0000_0000_0000);
`endif

    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      applyStimulus(pickOperand(), pickOperand(), 1'b1, t);
      if (i % 3 == 0) begin
        repeat ($urandom_range(1, 20)) @(negedge clk);
        applyStimulus($urandom, $urandom, 1'b0, t2);
      end
      waitIdle(LAT + 30);
    end

    // Product must hold while operands wander and no start arrives.
    holdExp = lastExpected;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      multiplicand = $urandom;
      multiplier   = $urandom;
      #1;
      checkOutput("holdProduct", product, holdExp);
      checkOutput("holdBusy", busy, 0);
      checkOutput("holdDone", done, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Sequential shift-add multiplier controller: an unsigned WIDTH x WIDTH multiply that takes one add/shift step per clock and produces a 2*WIDTH product.
- Owns the product/accumulator register, the step counter and the start/busy/done handshake.
- Drives one combinational step unit, which does a conditional add into the upper half followed by a 1-bit logical right shift.
- Sits beside the ALU; the CPU control unit starts it and stalls on busy.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH bits.
- CNT_W, 6, step-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request pulse; sampled only in IDLE or DONE
- multiplicand  in  WIDTH  operand A; latched on an accepted start
- multiplier  in  WIDTH  operand B; latched on an accepted start
- busy  out  1  high while an operation is in progress (RUN, or FIX when compiled in)
- done  out  1  one-cycle pulse; product is valid from this cycle on
- product  out  2*WIDTH  result register; holds its value until the next done

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, product=0; counter, accumulator and mcand_q cleared. Reset mid-operation aborts the operation; no done is produced.
- States: IDLE, RUN, DONE, plus FIX when MUL_SIGNED_EN is defined.
- IDLE/DONE with start=1 at edge T:
  - mcand_q <= multiplicand; acc <= {WIDTH zeros, multiplier}; cnt <= 0; state <= RUN.
  - busy reads 1 from T+ onward.
- RUN, each edge:
  - mark = acc[0].
  - upper = acc[2W-1:W] + (mark ? mcand_q : 0), computed as WIDTH+1 bits so the carry is kept.
  - acc <= {upper[W:0], acc[W-1:1]}; the carry enters bit 2W-1 and is never dropped.
  - cnt <= cnt+1.
- RUN, on the edge where cnt==WIDTH-1: state <= DONE and product <= the stepped acc value. Latency is start edge T to done high after edge T+WIDTH (WIDTH cycles).
- DONE: done=1, busy=0, for exactly one cycle. Next edge goes to IDLE, or to RUN if start=1 (back-to-back operation, no bubble).
- start while busy: ignored. Operands are not re-latched and the running operation is unaffected.
- Operand inputs may change freely after the accepted start edge.
- product changes only on the edge entering DONE.

Optional Feature:
- Macro: MUL_SIGNED_EN.
- Defined — two's-complement signed multiply:
  - On start, latch |multiplicand|, |multiplier| and neg = sign(A) XOR sign(B). |-2^(W-1)| = 2^(W-1) is representable unsigned.
  - After the last RUN step, go to FIX (busy=1) for one cycle: product <= neg ? -acc : acc.
  - Then DONE. Latency is WIDTH+1 cycles.
- Not defined — purely unsigned, no FIX state, latency WIDTH.

Decomposition:
- Package mul_pkg:
  - state enum (S_IDLE, S_RUN, S_DONE, S_FIX);
  - localparam MUL_WIDTH=32;
  - localparam MUL_CNT_W=6.
- One natural sub-module, mul_step_unit. It is combinational: inputs mark, mcand[W-1:0], acc[2W-1:0]; output next_acc[2W-1:0]; it keeps the carry-out.
- The controller instantiates one mul_step_unit and holds all registers.

Test Plan:
- Reset mid-RUN: start A=3, B=5; assert rst_n=0 at cycle 10 -> busy=0, done=0, product=0 immediately; no done ever follows.
- Carry retention: A=0xFFFFFFFF, B=0xFFFFFFFF -> done at T+32, product=0xFFFFFFFE00000001. Signed build: A=-1, B=-1 -> product=1 at T+33.
- Basic plus start-while-busy: A=6, B=7; re-pulse start with A=1, B=1 at T+5 -> single done at T+32, product=42.
- Back-to-back: start in the DONE cycle with A=0x10000, B=0x10000 -> no idle cycle; second done 32 cycles later, product=0x100000000. Zero operand: A=0, B=0xDEADBEEF -> product=0.
- Signed (MUL_SIGNED_EN): A=-7, B=6 -> product=0xFFFFFFFFFFFFFFD6. A=0x80000000, B=0x80000000 -> product=0x4000000000000000.
- Hold: after done, toggle operands with no start for 50 cycles -> product stable, busy=0, done=0.
